// File: rtl/rggen_apb_bridge.sv
// rggen_apb_bridge: APB3/APB4 slave to rggen register-bus bridge, one transfer in flight.
// Define RGGEN_APB_BRIDGE_DECODE_ERROR_EN to answer unmapped accesses with PSLVERR=1.
module rggen_apb_bridge #(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_psel,
  input  logic                                  i_penable,
  input  logic [ADDRESS_WIDTH-1:0]              i_paddr,
  input  logic                                  i_pwrite,
  input  logic [DATA_WIDTH-1:0]                 i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]               i_pstrb,
  output logic                                  o_pready,
  output logic [DATA_WIDTH-1:0]                 o_prdata,
  output logic                                  o_pslverr,
  output logic                                  o_request,
  output logic [ADDRESS_WIDTH-1:0]              o_address,
  output logic                                  o_direction,
  output logic [DATA_WIDTH-1:0]                 o_write_data,
  output logic [DATA_WIDTH/8-1:0]               o_write_strobe,
  input  logic [TOTAL_REGISTERS-1:0]            i_select,
  input  logic [TOTAL_REGISTERS-1:0]            i_ready,
  input  logic [2*TOTAL_REGISTERS-1:0]          i_status,
  input  logic [DATA_WIDTH*TOTAL_REGISTERS-1:0] i_read_data
);
  localparam int         STRB_WIDTH         = DATA_WIDTH / 8;
  localparam logic [1:0] STATUS_SLAVE_ERROR = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic                     direction_q;
  logic [DATA_WIDTH-1:0]    write_data_q;
  logic [STRB_WIDTH-1:0]    write_strobe_q;
  logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
  logic                     slverr_q, slverr_d;

  logic                     setup;
  logic                     any_ready;
  logic                     any_select;
  logic                     decode_error;
  logic [DATA_WIDTH-1:0]    masked_data   [TOTAL_REGISTERS];
  logic [1:0]               masked_status [TOTAL_REGISTERS];
  logic [DATA_WIDTH-1:0]    ready_data;
  logic [1:0]               ready_status;

  // Only a true setup phase starts a transfer; a lingering access phase is not a new request.
  assign setup      = i_psel && !i_penable;
  assign any_ready  = |i_ready;
  assign any_select = |i_select;

`ifdef RGGEN_APB_BRIDGE_DECODE_ERROR_EN
  assign decode_error = 1'b1;
`else
  assign decode_error = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < TOTAL_REGISTERS; gi++) begin : g_slot
      localparam logic [TOTAL_REGISTERS-1:0] LOWER_MASK =
        TOTAL_REGISTERS'((64'd1 << gi) - 64'd1);
      logic first_ready;
      // Status comes from the lowest-indexed ready slot only; data is plainly ORed.
      assign first_ready        = i_ready[gi] && ((i_ready & LOWER_MASK) == '0);
      assign masked_data[gi]    = i_ready[gi] ? i_read_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign masked_status[gi]  = first_ready ? i_status[2*gi +: 2] : 2'd0;
    end
  endgenerate

  always_comb begin
    ready_data   = '0;
    ready_status = 2'd0;
    for (int k = 0; k < TOTAL_REGISTERS; k++) begin
      ready_data   = ready_data | masked_data[k];
      ready_status = ready_status | masked_status[k];
    end
  end

  always_comb begin
    read_data_d = '0;
    slverr_d    = decode_error;
    if (any_ready) begin
      read_data_d = direction_q ? '0 : ready_data;
      slverr_d    = (ready_status == STATUS_SLAVE_ERROR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup) state_d = REQUEST;
      REQUEST: if (any_ready || !any_select) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_q      <= '0;
      direction_q    <= 1'b0;
      write_data_q   <= '0;
      write_strobe_q <= '0;
      read_data_q    <= '0;
      slverr_q       <= 1'b0;
    end else begin
      if ((state_q == IDLE) && setup) begin
        address_q      <= i_paddr;
        direction_q    <= i_pwrite;
        write_data_q   <= i_pwdata;
        write_strobe_q <= i_pwrite ? i_pstrb : '0;
      end
      if ((state_q == REQUEST) && (state_d == RESPOND)) begin
        read_data_q <= read_data_d;
        slverr_q    <= slverr_d;
      end
    end
  end

  always_comb begin
    o_request      = (state_q == REQUEST);
    o_pready       = (state_q == RESPOND);
    o_prdata       = (state_q == RESPOND) ? read_data_q : '0;
    o_pslverr      = (state_q == RESPOND) ? slverr_q : 1'b0;
    o_address      = address_q;
    o_direction    = direction_q;
    o_write_data   = write_data_q;
    o_write_strobe = write_strobe_q;
  end

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Scoreboard bench for rggen_apb_bridge: directed APB transfers against a three-slot register model.
module tb_rggen_apb_bridge;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 3;

`ifdef RGGEN_APB_BRIDGE_DECODE_ERROR_EN
  localparam logic DEC_ERR = 1'b1;
`else
  localparam logic DEC_ERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic            o_pready, o_pslverr, o_request, o_direction;
  logic [DW-1:0]   o_prdata, o_write_data;
  logic [AW-1:0]   o_address;
  logic [DW/8-1:0] o_write_strobe;
  logic [NR-1:0]   i_select, i_ready;
  logic [2*NR-1:0] i_status;
  logic [DW*NR-1:0] i_read_data;

  logic [NR-1:0]   cfg_mask;
  int              cfg_delay;
  logic [2*NR-1:0] cfg_status;
  int              wait_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            dir;
    logic [DW-1:0]   wd;
    logic [DW/8-1:0] strb;
  } req_t;
  typedef struct packed {
    logic [DW-1:0] rd;
    logic          err;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  req_t  exp_req;
  resp_t exp_resp;
  logic  prev_req = 1'b0;

  always #5 clk = ~clk;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_psel(psel), .i_penable(penable), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(o_pready), .o_prdata(o_prdata), .o_pslverr(o_pslverr),
    .o_request(o_request), .o_address(o_address), .o_direction(o_direction),
    .o_write_data(o_write_data), .o_write_strobe(o_write_strobe),
    .i_select(i_select), .i_ready(i_ready), .i_status(i_status), .i_read_data(i_read_data)
  );

  // Register model: selected slots become ready after cfg_delay request cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wait_cnt <= 0;
    else if (o_request) wait_cnt <= wait_cnt + 1;
    else                wait_cnt <= 0;
  end

  always_comb begin
    i_select    = cfg_mask;
    i_ready     = (o_request && (wait_cnt >= cfg_delay)) ? cfg_mask : '0;
    i_status    = cfg_status;
    i_read_data = {32'h0000_00F0, 32'h1234_5678, 32'hA5A5_0000};
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Monitor: pops expectations when the DUT issues a request or an APB response.
  always @(negedge clk) begin
    if (o_request && !prev_req) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_request actual=%0h required=none", o_address);
      end else begin
        exp_req = req_q.pop_front();
        chk("req_address", 64'(o_address), 64'(exp_req.addr));
        chk("req_direction", 64'(o_direction), 64'(exp_req.dir));
        chk("req_strobe", 64'(o_write_strobe), 64'(exp_req.strb));
        if (exp_req.dir) chk("req_wdata", 64'(o_write_data), 64'(exp_req.wd));
        $display("req  addr=%h dir=%0d strb=%h wdata=%h", o_address, o_direction, o_write_strobe, o_write_data);
      end
    end
    prev_req = o_request;
    if (o_pready) begin
      checks++;
      if (resp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pready actual=%h required=none", o_prdata);
      end else begin
        exp_resp = resp_q.pop_front();
        chk("resp_prdata", 64'(o_prdata), 64'(exp_resp.rd));
        chk("resp_pslverr", 64'(o_pslverr), 64'(exp_resp.err));
        $display("resp prdata=%h pslverr=%0d", o_prdata, o_pslverr);
      end
    end else begin
      chk("idle_response_zero", {31'd0, o_pslverr, o_prdata}, 64'd0);
    end
  end

  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                      input logic [DW/8-1:0] st, input logic [NR-1:0] mask, input int dly,
                      input logic [2*NR-1:0] stat, input logic [DW-1:0] exp_rd,
                      input logic exp_err, input logic b2b);
    int n;
    int rq;
    cfg_mask   = mask;
    cfg_delay  = dly;
    cfg_status = stat;
    req_q.push_back('{addr, wr, wd, (wr ? st : 4'h0)});
    resp_q.push_back('{exp_rd, exp_err});
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("request_at_T1", 64'(o_request), 64'd1);
    rq = 1;
    n  = 0;
    while (!o_pready && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (o_request) rq++;
    end
    chk("pready_latency", 64'(n), 64'(dly + 1));
    chk("request_cycles", 64'(rq), 64'(dly + 1));
    @(posedge clk); #1;
    chk("pready_single_cycle", 64'(o_pready), 64'd0);
    if (!b2b) begin
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    psel = 1'b1; penable = 1'b0; paddr = 16'h1234; pwrite = 1'b1;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    cfg_mask = '0; cfg_delay = 0; cfg_status = '0;
    #12;
    chk("reset_request", 64'(o_request), 64'd0);
    chk("reset_pready", 64'(o_pready), 64'd0);
    chk("reset_address", 64'(o_address), 64'd0);
    chk("reset_direction", 64'(o_direction), 64'd0);
    chk("reset_wdata", 64'(o_write_data), 64'd0);
    chk("reset_strobe", 64'(o_write_strobe), 64'd0);
    #8 psel = 1'b0;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_spurious_request", 64'(o_request), 64'd0);
    end

    // addr, wr, wdata, strb, mask, delay, status, exp_rdata, exp_err, back-to-back
    xfer(16'h0010, 1'b1, 32'hDEAD_BEEF, 4'h3, 3'b100, 0, 6'b00_00_00, 32'h0,         1'b0,    1'b0);
    xfer(16'h0020, 1'b0, 32'h0,         4'hF, 3'b010, 3, 6'b00_00_00, 32'h1234_5678, 1'b0,    1'b0);
    xfer(16'h0FFC, 1'b0, 32'h0,         4'hF, 3'b000, 0, 6'b00_00_00, 32'h0,         DEC_ERR, 1'b0);
    xfer(16'h0010, 1'b1, 32'h0000_1111, 4'hF, 3'b100, 0, 6'b10_00_00, 32'h0,         1'b1,    1'b1);
    xfer(16'h0008, 1'b0, 32'h0,         4'hF, 3'b001, 1, 6'b00_00_01, 32'hA5A5_0000, 1'b0,    1'b0);
    xfer(16'h0020, 1'b0, 32'h0,         4'hF, 3'b110, 0, 6'b10_00_00, 32'h1234_56F8, 1'b0,    1'b0);
    xfer(16'h0FFC, 1'b1, 32'hCAFE_F00D, 4'hC, 3'b000, 0, 6'b00_00_00, 32'h0,         DEC_ERR, 1'b0);
    xfer(16'h0010, 1'b0, 32'h0,         4'hF, 3'b100, 2, 6'b10_00_00, 32'h0000_00F0, 1'b1,    1'b0);

    // Reset pulse in REQUEST: the pending request is dropped with no response.
    cfg_mask = 3'b010; cfg_delay = 5; cfg_status = '0;
    req_q.push_back('{16'h0020, 1'b0, 32'h0, 4'h0});
    psel = 1'b1; penable = 1'b0; paddr = 16'h0020; pwrite = 1'b0; pwdata = '0; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("abort_request_before", 64'(o_request), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_request_dropped", 64'(o_request), 64'd0);
    chk("abort_no_pready", 64'(o_pready), 64'd0);
    chk("abort_address_reset", 64'(o_address), 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_after", 64'(o_request), 64'd0);

    xfer(16'h0020, 1'b0, 32'h0, 4'hF, 3'b010, 0, 6'b00_00_00, 32'h1234_5678, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
